// File: rtl/game_pkg.sv
// Shared encodings for the whack-an-engineer game: slot states, slot count and
// the main game FSM states.
package game_pkg;

  localparam int NUM_MOLES = 5;

  typedef enum logic [1:0] {
    OFFSCREEN = 2'd0,
    ONSCREEN  = 2'd1,
    HIT       = 2'd2,
    MISS      = 2'd3
  } slot_state_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STARTGAME = 2'd1,
    INGAME    = 2'd2,
    GAMEOVER  = 2'd3
  } game_state_t;

  // Reduces 0..9 into a slot index 0..4 (used for mod-5 and wrap-around scan).
  function automatic logic [2:0] wrap_slot(input logic [3:0] idx);
    logic [3:0] r;
    r = (idx >= 4'd5) ? idx - 4'd5 : idx;
    return r[2:0];
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole slot: lifecycle FSM plus its shared lifetime/show counter.
// kill overrides everything; the parent only spawns into OFFSCREEN slots.
module mole_slot
  import game_pkg::*;
#(
  parameter int CW      = 26,
  parameter int LIFE_TC = 49999999,
  parameter int SHOW_TC = 12499999
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kill,
  input  logic       spawn,
  input  logic       hit,
  output logic [1:0] state,
  output logic [1:0] state_next,
  output logic       expire
);

  slot_state_t   st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q  <= OFFSCREEN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (kill) begin
      st_d  = OFFSCREEN;
      cnt_d = '0;
    end else begin
      case (st_q)
        OFFSCREEN: begin
          if (spawn) begin
            st_d  = ONSCREEN;
            cnt_d = '0;
          end
        end
        ONSCREEN: begin
          // A hit on the expiry cycle wins, so no miss is produced.
          if (hit) begin
            st_d  = HIT;
            cnt_d = '0;
          end else if (cnt_q == CW'(LIFE_TC)) begin
            st_d  = MISS;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == CW'(SHOW_TC)) begin
            st_d  = OFFSCREEN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    state      = st_q;
    state_next = st_d;
    expire     = !kill && (st_q == ONSCREEN) && !hit && (cnt_q == CW'(LIFE_TC));
  end

endmodule

// File: rtl/mole_slot_manager.sv
// Mole lifecycle engine: spawn timer + LFSR slot picker, five slot FSMs,
// swing resolution into hit/miss events. All outputs registered.
module mole_slot_manager
  import game_pkg::*;
#(
  parameter int         LIFETIME_CYCLES = 50000000,
  parameter int         SPAWN_INTERVAL  = 25000000,
  parameter int         SHOW_CYCLES     = 12500000,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_active,
  input  logic       clear,
  input  logic       hit_valid,
  input  logic [2:0] hit_index,
  output logic [4:0] moles_visible,
  output logic [9:0] slot_state,
  output logic       hit_pulse,
  output logic [2:0] hit_position,
  output logic [2:0] miss_count,
  output logic [2:0] active_count
);

  localparam int MAX_A   = (LIFETIME_CYCLES > SPAWN_INTERVAL) ? LIFETIME_CYCLES : SPAWN_INTERVAL;
  localparam int MAX_CYC = (MAX_A > SHOW_CYCLES) ? MAX_A : SHOW_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [CW-1:0]  spawn_cnt;
  logic [7:0]     lfsr;
  logic           attempt, kill, hit_ok, bad_swing, found;
  logic [2:0]     cand, idx, miss_sum, next_active;
  logic [4:0]     spawn_vec, hit_vec, expire_vec, on_vec, off_vec, next_on_vec;
  logic [1:0]     st    [NUM_MOLES];
  logic [1:0]     st_nx [NUM_MOLES];

  assign kill    = clear || !game_active;
  assign attempt = game_active && !clear && (spawn_cnt == CW'(SPAWN_INTERVAL - 1));

  // Candidate from the LFSR, then first free slot scanning upward with wrap.
  always_comb begin
    spawn_vec = '0;
    found     = 1'b0;
    idx       = '0;
    cand      = wrap_slot({1'b0, lfsr[2:0]});
    for (int k = 0; k < NUM_MOLES; k++) begin
      idx = wrap_slot({1'b0, cand} + 4'(k));
      if (attempt && !found && off_vec[idx]) begin
        spawn_vec[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // Swings are resolved against the pre-update slot states.
  always_comb begin
    for (int i = 0; i < NUM_MOLES; i++) begin
      hit_vec[i] = game_active && hit_valid && (hit_index == 3'(i)) && on_vec[i];
    end
    hit_ok    = !clear && (|hit_vec);
    bad_swing = !clear && game_active && hit_valid && !(|hit_vec);
    miss_sum  = {2'b00, bad_swing};
    next_active = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      miss_sum    = miss_sum + {2'b00, expire_vec[i]};
      next_active = next_active + {2'b00, next_on_vec[i]};
    end
  end

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_slot
    mole_slot #(
      .CW     (CW),
      .LIFE_TC(LIFETIME_CYCLES - 1),
      .SHOW_TC(SHOW_CYCLES - 1)
    ) u_slot (
      .clock     (clock),
      .reset     (reset),
      .kill      (kill),
      .spawn     (spawn_vec[g]),
      .hit       (hit_vec[g]),
      .state     (st[g]),
      .state_next(st_nx[g]),
      .expire    (expire_vec[g])
    );
    assign on_vec[g]             = (st[g] == ONSCREEN);
    assign off_vec[g]            = (st[g] == OFFSCREEN);
    assign next_on_vec[g]        = (st_nx[g] == ONSCREEN);
    assign slot_state[2*g+1:2*g] = st[g];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spawn_cnt     <= '0;
      lfsr          <= LFSR_SEED;
      moles_visible <= '0;
      active_count  <= '0;
      hit_pulse     <= 1'b0;
      hit_position  <= '0;
      miss_count    <= '0;
    end else if (clear) begin
      spawn_cnt     <= '0;
      lfsr          <= LFSR_SEED;
      moles_visible <= '0;
      active_count  <= '0;
      hit_pulse     <= 1'b0;
      hit_position  <= '0;
      miss_count    <= '0;
    end else begin
      if (!game_active || attempt) spawn_cnt <= '0;
      else                         spawn_cnt <= spawn_cnt + CW'(1);
      // LFSR steps on every attempt, even a skipped one.
      if (attempt) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (hit_ok)  hit_position <= hit_index;
      hit_pulse     <= hit_ok;
      miss_count    <= miss_sum;
      moles_visible <= next_on_vec;
      active_count  <= next_active;
    end
  end

endmodule

// File: tb/tb_mole_slot_manager.sv
// Directed bench for mole_slot_manager with short timings (life 8, spawn 4,
// show 2); a second instance with a long lifetime covers the all-slots-busy case.
module tb_mole_slot_manager;

  logic       clock;
  logic       reset;
  logic       game_active;
  logic       clear;
  logic       hit_valid;
  logic [2:0] hit_index;

  logic [4:0] mv, f_mv;
  logic [9:0] ss, f_ss;
  logic       hp, f_hp;
  logic [2:0] hpos, f_hpos;
  logic [2:0] mc, f_mc;
  logic [2:0] ac, f_ac;

  int n_checks = 0;
  int n_pass   = 0;

  mole_slot_manager #(
    .LIFETIME_CYCLES(8), .SPAWN_INTERVAL(4), .SHOW_CYCLES(2), .LFSR_SEED(8'hA5)
  ) dut (
    .clock(clock), .reset(reset), .game_active(game_active), .clear(clear),
    .hit_valid(hit_valid), .hit_index(hit_index),
    .moles_visible(mv), .slot_state(ss), .hit_pulse(hp), .hit_position(hpos),
    .miss_count(mc), .active_count(ac)
  );

  mole_slot_manager #(
    .LIFETIME_CYCLES(64), .SPAWN_INTERVAL(4), .SHOW_CYCLES(2), .LFSR_SEED(8'hA5)
  ) dut_full (
    .clock(clock), .reset(reset), .game_active(game_active), .clear(clear),
    .hit_valid(hit_valid), .hit_index(hit_index),
    .moles_visible(f_mv), .slot_state(f_ss), .hit_pulse(f_hp), .hit_position(f_hpos),
    .miss_count(f_mc), .active_count(f_ac)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    hit_valid   = 1'b0;
    game_active = 1'b1;
    clear       = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic swing(input logic [2:0] idx);
    hit_valid = 1'b1;
    hit_index = idx;
    step();
    hit_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; game_active = 1'b0; clear = 1'b0; hit_valid = 1'b0; hit_index = '0;
    steps(2);
    n_checks++; if (mv !== 5'd0) $display("FAIL reset_visible got %b want 00000", mv); else n_pass++;
    n_checks++; if (ss !== 10'd0) $display("FAIL reset_slot_state got %h want 000", ss); else n_pass++;
    n_checks++; if ({hp, hpos, mc, ac} !== 10'd0) $display("FAIL reset_misc got %b want 0", {hp, hpos, mc, ac}); else n_pass++;
    reset = 1'b0;
    do_clear();
    n_checks++; if ({mv, ss, f_mv} !== 20'd0) $display("FAIL clear_state got %h want 0", {mv, ss, f_mv}); else n_pass++;
  endtask

  // Slot 0 spawns on the 4th active edge, expires 8 edges later, leaves 2 after that.
  task automatic test_spawn_miss();
    logic [2:0] exp_q[$];
    logic [2:0] exp;
    do_clear();
    steps(3);
    n_checks++; if (mv !== 5'b00000) $display("FAIL s1_pre_spawn got %b want 00000", mv); else n_pass++;
    step();
    n_checks++; if (mv !== 5'b00001) $display("FAIL s1_spawn_visible got %b want 00001", mv); else n_pass++;
    n_checks++; if (ac !== 3'd1) $display("FAIL s1_spawn_active got %0d want 1", ac); else n_pass++;
    n_checks++; if (ss !== 10'h001) $display("FAIL s1_spawn_state got %h want 001", ss); else n_pass++;
    for (int e = 5; e <= 14; e++) exp_q.push_back((e == 12) ? 3'd1 : 3'd0);
    for (int e = 5; e <= 14; e++) begin
      step();
      exp = exp_q.pop_front();
      n_checks++; if (mc !== exp) $display("FAIL s1_miss_e%0d got %0d want %0d", e, mc, exp); else n_pass++;
      if (e == 12) begin
        n_checks++; if (ss !== 10'h017) $display("FAIL s1_expire_state got %h want 017", ss); else n_pass++;
        n_checks++; if (mv !== 5'b00110) $display("FAIL s1_expire_visible got %b want 00110", mv); else n_pass++;
        n_checks++; if (ac !== 3'd2) $display("FAIL s1_expire_active got %0d want 2", ac); else n_pass++;
      end
      if (e == 14) begin
        n_checks++; if (ss !== 10'h014) $display("FAIL s1_offscreen_state got %h want 014", ss); else n_pass++;
      end
    end
  endtask

  // Hit slot 0 on the very cycle its lifetime would end.
  task automatic test_hit();
    do_clear();
    steps(11);
    swing(3'd0);
    n_checks++; if (hp !== 1'b1) $display("FAIL s2_hit_pulse got %b want 1", hp); else n_pass++;
    n_checks++; if (hpos !== 3'd0) $display("FAIL s2_hit_position got %0d want 0", hpos); else n_pass++;
    n_checks++; if (ss[1:0] !== 2'd2) $display("FAIL s2_slot0_state got %0d want 2", ss[1:0]); else n_pass++;
    n_checks++; if (mv !== 5'b00110) $display("FAIL s2_visible got %b want 00110", mv); else n_pass++;
    n_checks++; if (mc !== 3'd0) $display("FAIL s2_no_miss got %0d want 0", mc); else n_pass++;
    step();
    n_checks++; if ({hp, mc} !== 4'd0) $display("FAIL s2_pulse_one_cycle got %b want 0000", {hp, mc}); else n_pass++;
    step();
    n_checks++; if (ss[1:0] !== 2'd0) $display("FAIL s2_offscreen got %0d want 0", ss[1:0]); else n_pass++;
  endtask

  task automatic test_bad_swing();
    do_clear();
    swing(3'd6);
    n_checks++; if (mc !== 3'd1) $display("FAIL s3_invalid_miss got %0d want 1", mc); else n_pass++;
    n_checks++; if ({hp, ss} !== 11'd0) $display("FAIL s3_invalid_nochange got %h want 0", {hp, ss}); else n_pass++;
    swing(3'd3);
    n_checks++; if (mc !== 3'd1) $display("FAIL s3_offscreen_miss got %0d want 1", mc); else n_pass++;
    n_checks++; if ({hp, ss} !== 11'd0) $display("FAIL s3_offscreen_nochange got %h want 0", {hp, ss}); else n_pass++;
    step();
    n_checks++; if (mc !== 3'd0) $display("FAIL s3_idle_miss got %0d want 0", mc); else n_pass++;
    swing(3'd0);
    n_checks++; if (mc !== 3'd1) $display("FAIL s3_spawn_swing_miss got %0d want 1", mc); else n_pass++;
    n_checks++; if ({mv, hp} !== 6'b000010) $display("FAIL s3_spawn_swing_state got %b want 000010", {mv, hp}); else n_pass++;
  endtask

  // Long-lifetime instance: fill all slots, free 1 and 3, confirm the skipped
  // attempt still stepped the LFSR (next candidate 3, not 1).
  task automatic test_all_busy();
    do_clear();
    steps(20);
    n_checks++; if (f_mv !== 5'b11111) $display("FAIL s4_full_visible got %b want 11111", f_mv); else n_pass++;
    n_checks++; if (f_ac !== 3'd5) $display("FAIL s4_full_active got %0d want 5", f_ac); else n_pass++;
    step();
    swing(3'd1);
    n_checks++; if ({f_hp, f_hpos, f_mc} !== 7'b1_001_000) $display("FAIL s4_hit1 got %b want 1001000", {f_hp, f_hpos, f_mc}); else n_pass++;
    swing(3'd3);
    n_checks++; if ({f_hpos, f_ac} !== 6'b011_011) $display("FAIL s4_hit3 got %b want 011011", {f_hpos, f_ac}); else n_pass++;
    step();
    n_checks++; if (f_ss !== 10'h191) $display("FAIL s4_skip_state got %h want 191", f_ss); else n_pass++;
    n_checks++; if (f_ac !== 3'd3) $display("FAIL s4_skip_active got %0d want 3", f_ac); else n_pass++;
    steps(4);
    n_checks++; if (f_mv !== 5'b11101) $display("FAIL s4_lfsr_advanced got %b want 11101", f_mv); else n_pass++;
    n_checks++; if (f_ac !== 3'd4) $display("FAIL s4_refill_active got %0d want 4", f_ac); else n_pass++;
  endtask

  // Hit slot 2 on the edge slot 0 expires.
  task automatic test_hit_and_expire();
    do_clear();
    steps(11);
    swing(3'd2);
    n_checks++; if ({hp, hpos, mc} !== 7'b1_010_001) $display("FAIL s5_hit_miss got %b want 1010001", {hp, hpos, mc}); else n_pass++;
    n_checks++; if (ss !== 10'h027) $display("FAIL s5_state got %h want 027", ss); else n_pass++;
    n_checks++; if ({mv, ac} !== 8'b00010_001) $display("FAIL s5_visible got %b want 00010001", {mv, ac}); else n_pass++;
  endtask

  task automatic test_async_reset();
    step();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    n_checks++; if ({mv, ss, hp, hpos, mc, ac} !== 25'd0) $display("FAIL s6_async_reset got %h want 0", {mv, ss, hp, hpos, mc, ac}); else n_pass++;
    n_checks++; if ({f_mv, f_ac} !== 8'd0) $display("FAIL s6_async_reset_full got %h want 0", {f_mv, f_ac}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_inactive();
    do_clear();
    steps(8);
    n_checks++; if (mv !== 5'b00101) $display("FAIL s6_active_visible got %b want 00101", mv); else n_pass++;
    game_active = 1'b0;
    step();
    n_checks++; if ({mv, ss, ac} !== 18'd0) $display("FAIL s6_drop_active got %h want 0", {mv, ss, ac}); else n_pass++;
    swing(3'd2);
    n_checks++; if ({hp, mc, ss} !== 14'd0) $display("FAIL s6_swing_ignored got %h want 0", {hp, mc, ss}); else n_pass++;
    steps(8);
    n_checks++; if (mv !== 5'd0) $display("FAIL s6_no_spawn_inactive got %b want 00000", mv); else n_pass++;
    game_active = 1'b1;
    steps(3);
    n_checks++; if (mv !== 5'd0) $display("FAIL s6_resume_pre got %b want 00000", mv); else n_pass++;
    step();
    n_checks++; if (mv !== 5'b00001) $display("FAIL s6_resume_spawn got %b want 00001", mv); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_spawn_miss();
    test_hit();
    test_bad_swing();
    test_all_busy();
    test_hit_and_expire();
    test_async_reset();
    test_inactive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
